// File: rtl/mips32_imem_ctrl_pkg.sv
// Shared types and constants for the MIPS32 instruction-memory controller.
package mips32_imem_ctrl_pkg;

  localparam int         IMEM_ADDR_W = 10;
  localparam logic [5:0] HLT_OPCODE  = 6'b111111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    RUN   = 3'd3,
    HALT  = 3'd4
  } imem_state_t;

  // External 2-bit state code: READY and RUN share 2'b10 (pipe_stall tells them apart).
  function automatic logic [1:0] state_code(input imem_state_t s);
    case (s)
      IDLE:       state_code = 2'b00;
      LOAD:       state_code = 2'b01;
      READY, RUN: state_code = 2'b10;
      default:    state_code = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/mips32_imem_ctrl_if.sv
// Load stream, IF fetch port and instruction-memory port of the imem controller.
interface mips32_imem_ctrl_if
  import mips32_imem_ctrl_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = 32
);

  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;

  logic              if_req;
  logic [31:0]       if_pc;
  logic [DATA_W-1:0] if_instr;
  logic              if_valid;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // master: the controller; slave: loader, IF stage and the memory macro
  modport master (
    input  ld_valid, ld_data, ld_last, if_req, if_pc, mem_rdata,
    output ld_ready, if_instr, if_valid, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output ld_valid, ld_data, ld_last, if_req, if_pc, mem_rdata,
    input  ld_ready, if_instr, if_valid, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mips32_imem_fetch_pipe.sv
// Read-return stage: one cycle after an issued fetch, presents the memory word, flags HLT
// and counts deliveries; no backpressure, an issued fetch is always delivered next cycle.
module mips32_imem_fetch_pipe #(
  parameter int         DATA_W     = 32,
  parameter logic [5:0] HLT_OPCODE = 6'b111111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [DATA_W-1:0] rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic              hlt_hit,
  output logic [31:0]       fetch_count
);

  logic pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= 1'b0;
      fetch_count <= '0;
    end else begin
      pend <= issue;
      if (pend) fetch_count <= fetch_count + 32'd1;
    end
  end

  assign if_valid = pend;
  assign if_instr = pend ? rdata : '0;
  assign hlt_hit  = pend && (rdata[DATA_W-1 -: 6] == HLT_OPCODE);

endmodule

// File: rtl/mips32_imem_ctrl.sv
// Instruction-memory sequencer: loads a program image, then serves IF fetches with 1-cycle
// read latency until HLT or a fault; ld_ready drops once the image is complete.
module mips32_imem_ctrl #(
  parameter int          ADDR_W     = mips32_imem_ctrl_pkg::IMEM_ADDR_W,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] BOOT_PC    = 32'h0000_0000,
  parameter logic [5:0]  HLT_OPCODE = mips32_imem_ctrl_pkg::HLT_OPCODE
) (
  input  logic               clk,
  input  logic               rst,
  mips32_imem_ctrl_if.master bus,
  input  logic               start,
  output logic               pipe_stall,
  output logic [1:0]         state_o,
  output logic [ADDR_W:0]    load_count,
  output logic [31:0]        fetch_count,
  output logic               halted,
  output logic               fault
);

  import mips32_imem_ctrl_pkg::*;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  imem_state_t state, state_n;
  logic        load_inc, fault_set, halt_set, issue, hlt_hit, pc_bad;
  logic [31:0] pc_off;

  // Word 0 of the image lives at BOOT_PC; range/alignment are checked on the offset.
  assign pc_off = bus.if_pc - BOOT_PC;
  assign pc_bad = (pc_off[1:0] != 2'b00) || (pc_off[31:ADDR_W+2] != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_count <= '0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state <= state_n;
      if (load_inc)  load_count <= load_count + 1'b1;
      if (fault_set) fault      <= 1'b1;
      if (halt_set)  halted     <= 1'b1;
    end
  end

  always_comb begin
    state_n      = state;
    bus.ld_ready = 1'b0;
    bus.mem_we   = 1'b0;
    load_inc     = 1'b0;
    fault_set    = 1'b0;
    halt_set     = 1'b0;
    issue        = 1'b0;
    unique case (state)
      IDLE, LOAD: begin
        bus.ld_ready = 1'b1;
        if (bus.ld_valid) begin
          if (load_count == DEPTH) begin
            fault_set = 1'b1;
            state_n   = HALT;
          end else begin
            bus.mem_we = 1'b1;
            load_inc   = 1'b1;
            state_n    = bus.ld_last ? READY : LOAD;
          end
        end
      end
      READY: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        // A delivered HLT swallows any request made in the same cycle.
        if (hlt_hit) begin
          halt_set = 1'b1;
          state_n  = HALT;
        end else if (bus.if_req) begin
          if (pc_bad) begin
            fault_set = 1'b1;
            state_n   = HALT;
          end else begin
            issue = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_addr  = (state == RUN) ? pc_off[ADDR_W+1:2] : load_count[ADDR_W-1:0];
  assign bus.mem_wdata = bus.mem_we ? bus.ld_data : '0;
  assign pipe_stall    = (state != RUN);
  assign state_o       = state_code(state);

  mips32_imem_fetch_pipe #(
    .DATA_W     (DATA_W),
    .HLT_OPCODE (HLT_OPCODE)
  ) u_fetch_pipe (
    .clk         (clk),
    .rst         (rst),
    .issue       (issue),
    .rdata       (bus.mem_rdata),
    .if_valid    (bus.if_valid),
    .if_instr    (bus.if_instr),
    .hlt_hit     (hlt_hit),
    .fetch_count (fetch_count)
  );

endmodule

// File: tb/tb_mips32_imem_ctrl.sv
// Bench for mips32_imem_ctrl: RAM model, randomized load/fetch traffic, transaction-level reference.
module tb_mips32_imem_ctrl;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pipe_stall, halted, fault;
  logic [1:0]    state_o;
  logic [AW:0]   load_count;
  logic [31:0]   fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [DEPTH];
  logic [31:0] img [DEPTH];

  // reference model state
  bit          m_run, m_pend, m_halted, m_fault;
  logic [31:0] m_word, m_fetch;
  int          m_loaded;

  always #5 clk = ~clk;

  mips32_imem_ctrl_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

  mips32_imem_ctrl #(
    .ADDR_W(AW), .DATA_W(32), .BOOT_PC(32'h0), .HLT_OPCODE(6'b111111)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .start(start), .pipe_stall(pipe_stall),
    .state_o(state_o), .load_count(load_count), .fetch_count(fetch_count),
    .halted(halted), .fault(fault)
  );

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
    bus.if_req = 1'b0; bus.if_pc = '0;
    step();
    check("rst_state", state_o, 0);
    check("rst_ld_ready", bus.ld_ready, 1);
    check("rst_stall", pipe_stall, 1);
    check("rst_load_count", load_count, 0);
    check("rst_fetch_count", fetch_count, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_if_valid", bus.if_valid, 0);
    check("rst_mem_we", bus.mem_we, 0);
    rst = 1'b0;
    m_run = 0; m_pend = 0; m_halted = 0; m_fault = 0; m_fetch = 0; m_word = 0; m_loaded = 0;
  endtask

  task automatic load_words(input int n, input bit last_on_final);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.ld_valid = 1'b0;
        @(negedge clk);
        check("ld_idle_we", bus.mem_we, 0);
        step();
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = img[m_loaded];
      bus.ld_last  = last_on_final && (i == n - 1);
      @(negedge clk);
      check("ld_ready", bus.ld_ready, 1);
      check("ld_we", bus.mem_we, 1);
      check("ld_addr", bus.mem_addr, m_loaded[AW-1:0]);
      check("ld_wdata", bus.mem_wdata, img[m_loaded]);
      step();
      m_loaded++;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    check("load_count", load_count, m_loaded);
    check("ld_state", state_o, last_on_final ? 2 : 1);
    check("ld_ready_after", bus.ld_ready, last_on_final ? 0 : 1);
  endtask

  task automatic check_mem(input int n);
    for (int i = 0; i < n; i++) check("mem_img", mem[i], img[i]);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    check("pre_start_stall", pipe_stall, 1);
    step();
    start = 1'b0;
    m_run = 1;
    check("start_stall", pipe_stall, 0);
    check("start_state", state_o, 2);
  endtask

  // One IF cycle: a request either returns its image word next cycle, faults, or is ignored.
  task automatic run_cycle(input bit req, input logic [31:0] pc);
    bit          hlt, nxt_pend;
    logic [31:0] nxt_word;
    bus.if_req = req;
    bus.if_pc  = pc;
    @(negedge clk);
    check("if_valid", bus.if_valid, m_pend);
    if (m_pend) check("if_instr", bus.if_instr, m_word);
    check("run_we", bus.mem_we, 0);
    hlt = m_pend && (m_word[31:26] == 6'h3f);
    if (m_pend) m_fetch++;
    nxt_pend = 0;
    nxt_word = '0;
    if (m_run) begin
      if (hlt) begin
        m_run = 0; m_halted = 1;
      end else if (req) begin
        if (pc[1:0] != 2'b00 || (pc >> (AW + 2)) != 0) begin
          m_run = 0; m_fault = 1;
        end else begin
          check("fetch_addr", bus.mem_addr, pc[AW+1:2]);
          nxt_pend = 1;
          nxt_word = img[pc[AW+1:2]];
        end
      end
    end
    m_pend = nxt_pend;
    m_word = nxt_word;
    step();
    bus.if_req = 1'b0;
    check("fetch_count", fetch_count, m_fetch);
    check("halted", halted, m_halted);
    check("fault", fault, m_fault);
    check("run_state", state_o, m_run ? 2 : 3);
    check("pipe_stall", pipe_stall, !m_run);
    check("ld_ready_run", bus.ld_ready, 0);
  endtask

  task automatic set_demo_prog();
    img[0] = 32'h2001_0005; img[1] = 32'h2002_0003;
    img[2] = 32'h0022_1820; img[3] = 32'hFC00_0000;
  endtask

  initial begin
    do_reset();

    // start with nothing loaded is ignored
    start = 1'b1; step(); start = 1'b0;
    check("idle_start_state", state_o, 0);
    check("idle_start_stall", pipe_stall, 1);
    step();
    check("idle_start_state2", state_o, 0);

    // directed program, HLT on the last word; request in the HLT cycle is dropped
    set_demo_prog();
    load_words(4, 1);
    check_mem(4);
    do_start();
    run_cycle(1, 32'd0); run_cycle(0, 32'd0); run_cycle(1, 32'd4);
    run_cycle(1, 32'd8); run_cycle(1, 32'd12); run_cycle(1, 32'd0);
    check("demo_fetch_count", fetch_count, 4);
    check("demo_halted", halted, 1);
    check("demo_stall", pipe_stall, 1);
    run_cycle(0, 32'd0);
    check("demo_hlt_valid_low", bus.if_valid, 0);

    // start and ld_valid together in READY: start wins, then a misaligned PC faults
    do_reset();
    img[0] = 32'h2001_0007;
    load_words(1, 1);
    start = 1'b1; bus.ld_valid = 1'b1; bus.ld_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("ready_no_we", bus.mem_we, 0);
    check("ready_no_ld_ready", bus.ld_ready, 0);
    step();
    start = 1'b0; bus.ld_valid = 1'b0;
    m_run = 1;
    check("ready_to_run", pipe_stall, 0);
    check("ready_load_count", load_count, 1);
    run_cycle(1, 32'd0);
    run_cycle(1, 32'h6);
    check("mis_fault", fault, 1);
    check("mis_halted", halted, 0);
    check("mis_state", state_o, 3);
    run_cycle(0, 32'd0);
    check("mis_no_valid", bus.if_valid, 0);

    // PC beyond the memory
    do_reset();
    img[0] = 32'h0000_0000;
    load_words(1, 1);
    do_start();
    run_cycle(1, 32'h0000_1000);
    check("range_fault", fault, 1);
    check("range_state", state_o, 3);

    // randomized programs and fetch streams
    for (int r = 0; r < 3; r++) begin
      int n;
      do_reset();
      n = $urandom_range(5, 24);
      for (int i = 0; i < n - 1; i++) begin
        img[i] = $urandom;
        if (img[i][31:26] == 6'h3f) img[i][31:26] = 6'h08;
      end
      img[n-1] = {6'h3f, 26'($urandom)};
      load_words(n, 1);
      check_mem(n);
      do_start();
      for (int k = 0; k < 40; k++)
        run_cycle($urandom_range(0, 2) != 0, 32'($urandom_range(0, n - 2)) << 2);
      run_cycle(1, 32'(n - 1) << 2);
      run_cycle(1'($urandom_range(0, 1)), 32'd0);
      run_cycle(0, 32'd0);
      check("rnd_halted", halted, 1);
    end

    // reset mid-load, then reload and run
    do_reset();
    set_demo_prog();
    load_words(2, 0);
    do_reset();
    check("midload_ld_ready", bus.ld_ready, 1);
    load_words(4, 1);
    check_mem(4);
    do_start();
    run_cycle(1, 32'd0); run_cycle(1, 32'd4); run_cycle(1, 32'd8);
    run_cycle(1, 32'd12); run_cycle(0, 32'd0); run_cycle(0, 32'd0);
    check("reload_halted", halted, 1);
    check("reload_fetch_count", fetch_count, 4);

    // fill the whole memory, one extra word overflows
    do_reset();
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
    load_words(DEPTH, 0);
    bus.ld_valid = 1'b1; bus.ld_data = 32'hA5A5_A5A5; bus.ld_last = 1'b0;
    @(negedge clk);
    check("ovf_no_we", bus.mem_we, 0);
    step();
    bus.ld_valid = 1'b0;
    check("ovf_fault", fault, 1);
    check("ovf_state", state_o, 3);
    check("ovf_load_count", load_count, DEPTH);
    check("ovf_ld_ready", bus.ld_ready, 0);
    check("ovf_stall", pipe_stall, 1);
    check("ovf_mem_first", mem[0], img[0]);
    check("ovf_mem_last", mem[DEPTH-1], img[DEPTH-1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips32_imem_ctrl.md
Name: mips32_imem_ctrl

Overview:
Sequencer that owns the instruction memory port of the MIPS32 pipeline. After reset it accepts a program image from the testbench or loader over a valid/ready stream and writes it into instruction memory. On start it releases the pipeline and serves IF-stage fetches. It stops the pipeline when a HLT instruction is fetched or a fault occurs.

Parameters:
ADDR_W, 10, instruction memory word-address width (depth = 2**ADDR_W words)
DATA_W, 32, instruction width
BOOT_PC, 32'h0000_0000, PC presented to IF when RUN is entered
HLT_OPCODE, 6'b111111, opcode field [31:26] that halts execution

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ld_valid  in  1  load word valid
ld_ready  out  1  controller accepts load word
ld_data  in  DATA_W  program word
ld_last  in  1  marks final word of image
start  in  1  single-cycle pulse: begin execution
if_req  in  1  IF stage requests instruction at if_pc
if_pc  in  32  byte PC from IF stage
if_instr  out  DATA_W  fetched instruction
if_valid  out  1  if_instr valid for PC issued previous cycle
pipe_stall  out  1  holds pipeline (PC and IF/ID regs frozen)
mem_we  out  1  instruction memory write enable
mem_addr  out  ADDR_W  instruction memory word address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data (synchronous, 1-cycle latency)
state_o  out  2  current FSM state (encoded per imem_state_t)
load_count  out  ADDR_W+1  words loaded
fetch_count  out  32  instructions delivered
halted  out  1  HLT fetched
fault  out  1  overflow or misaligned-PC error, sticky

Behaviour:
- Reset (sync, active-high, any state, including mid-load or mid-run):
  - State goes to IDLE.
  - All outputs 0, except pipe_stall=1 and ld_ready=1.
  - Counters cleared; halted and fault cleared.
- IDLE: ld_ready=1.
  - ld_valid & ld_ready: write ld_data to address load_count in the same cycle (mem_we=1); load_count++; go to LOAD.
  - If the accepted word also has ld_last=1, go directly to READY.
  - start while in IDLE with load_count==0 is ignored.
- LOAD: same write rule per accepted word.
  - ld_last accepted -> READY, ld_ready=0.
  - An accepted word when load_count==2**ADDR_W: no write, fault=1, go to HALT.
- READY: ld_ready=0, pipe_stall=1. start -> RUN.
- RUN: pipe_stall=0.
  - if_req: mem_addr=if_pc[ADDR_W+1:2].
  - Next cycle: if_valid=1 and if_instr=mem_rdata; fetch_count++.
  - if_pc[1:0]!=0 or if_pc[31:ADDR_W+2]!=0 on a request: fault=1, no if_valid, go to HALT.
  - Delivered instruction with [31:26]==HLT_OPCODE: if_valid=1 for that word, halted=1, HALT next cycle.
- HALT: pipe_stall=1, if_valid=0, ld_ready=0. Only rst exits.
- Simultaneous events:
  - start and ld_valid in READY: start wins (no load in READY).
  - HLT detected in the same cycle as a new if_req: the request is dropped.
- Arithmetic:
  - fetch_count wraps modulo 2**32.
  - load_count saturates at 2**ADDR_W.
- mem_we is asserted only in IDLE/LOAD on accepted words, never in RUN.

Decomposition:
- Package mips32 (shared) holds:
  - typedef enum logic [1:0] imem_state_t {IDLE, LOAD, READY, RUN}, with HALT taking code 2'b11 by folding READY into 2'b10.
  - Alternative: widen imem_state_t to 3 bits, which is the preferred choice.
  - constants HLT_OPCODE and IMEM_ADDR_W.
- One sub-module, mips32_imem_fetch_pipe: the 1-cycle read-return register (if_valid, if_instr, HLT decode, fetch_count).
- Keep the FSM in the top of the block.

Test Plan:
- Load 4 words {0x20010005, 0x20020003, 0x00221820, 0xFC000000}, last on word 4 -> mem writes to addresses 0..3; load_count=4; state READY; ld_ready=0.
- start, IF requests PC 0,4,8,12 -> if_valid one cycle after each request with the matching words; fetch_count=4; halted=1 after 0xFC000000; pipe_stall=1.
- Load 2**ADDR_W words without last, then one more -> no write for the extra word; fault=1; state HALT.
- RUN with if_pc=0x6 -> fault=1, no if_valid, HALT.
- rst asserted mid-LOAD after 2 words -> next cycle IDLE, load_count=0, ld_ready=1, pipe_stall=1; a reload works.
- start pulse in IDLE with nothing loaded -> remains IDLE, pipe_stall=1.
